// File: rtl/msd_seq_mac.sv
// Iterative MSD signed-digit multiply/multiply-accumulate: D multiplier digits per CALC cycle, carry-free redundant accumulator.
// Optional MSD_CONV_EN adds a CONV cycle and a two's-complement result_bin_o port.
module msd_seq_mac #(
  parameter int X = 33,
  parameter int Y = 33,
  parameter int D = 4,
  parameter int G = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [2*X-1:0]       in1_i,
  input  logic [2*Y-1:0]       in2_i,
  input  logic                 acc_en_i,
  input  logic                 neg_en_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*(X+Y+G)-1:0] result_o
`ifdef MSD_CONV_EN
  ,
  output logic [X+Y+G:0]       result_bin_o
`endif
);

  localparam int W  = X + Y + G;
  localparam int N  = (Y + D - 1) / D;
  localparam int MP = N * D;
  localparam int CW = $clog2(N + 1);
  localparam logic [2*W-1:0]  ZW = {W{2'b10}};
  localparam logic [2*MP-1:0] ZM = {MP{2'b10}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_CONV, S_DONE} state_t;

  function automatic logic dp(input logic [1:0] c);
    return c[1] & c[0];
  endfunction

  function automatic logic dn(input logic [1:0] c);
    return ~c[1] & c[0];
  endfunction

  function automatic logic [1:0] enc(input logic p, input logic n);
    return p ? 2'b11 : (n ? 2'b01 : 2'b10);
  endfunction

  function automatic logic [1:0] dmul(input logic [1:0] a, input logic [1:0] b);
    return enc((dp(a) & dp(b)) | (dn(a) & dn(b)), (dp(a) & dn(b)) | (dn(a) & dp(b)));
  endfunction

  // Radix-2 carry-free SD add: the transfer out of digit i is chosen from the
  // signs of digit i-1 so that interim + incoming transfer stays in {-1,0,+1}.
  // The transfer out of the top digit is dropped, giving modulo-2^W wrap.
  function automatic logic [2*W-1:0] sd_add(input logic [2*W-1:0] a, input logic [2*W-1:0] b);
    logic [W-1:0]   tp, tn, wp, wn;
    logic           nprev;
    int             s, z;
    logic [2*W-1:0] r;
    tp = '0; tn = '0; wp = '0; wn = '0; nprev = 1'b1; r = ZW;
    for (int i = 0; i < W; i++) begin
      s = int'(dp(a[2*i+:2])) + int'(dp(b[2*i+:2])) - int'(dn(a[2*i+:2])) - int'(dn(b[2*i+:2]));
      if (s == 2) begin
        if (i < W-1) tp[i+1] = 1'b1;
      end else if (s == -2) begin
        if (i < W-1) tn[i+1] = 1'b1;
      end else if (s == 1) begin
        if (nprev) begin
          if (i < W-1) tp[i+1] = 1'b1;
          wn[i] = 1'b1;
        end else wp[i] = 1'b1;
      end else if (s == -1) begin
        if (nprev) wn[i] = 1'b1;
        else begin
          if (i < W-1) tn[i+1] = 1'b1;
          wp[i] = 1'b1;
        end
      end
      nprev = !dn(a[2*i+:2]) && !dn(b[2*i+:2]);
    end
    for (int i = 0; i < W; i++) begin
      z = int'(wp[i]) - int'(wn[i]) + int'(tp[i]) - int'(tn[i]);
      r[2*i+:2] = enc(z > 0, z < 0);
    end
    return r;
  endfunction

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2*W-1:0]  acc_q, pp_q, mc_q;
  logic [2*MP-1:0] mp_q;
  logic            out_valid_q;
  logic [2*W-1:0]  acc_d, pp_d, pj, mc_init_d, mc_sh_d;
  logic [2*MP-1:0] mp_init_d, mp_sh_d;
  logic            accept;

  assign in_ready_o  = (state_q == S_IDLE) || (state_q == S_DONE && out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = out_valid_q;
  assign result_o    = acc_q;

  // Multiplicand is stored pre-negated and shifted left D digits per cycle;
  // multiplier shifts right so its low D digits always select the next group.
  always_comb begin
    mc_init_d = ZW;
    for (int i = 0; i < X; i++)
      mc_init_d[2*i+:2] = neg_en_i ? enc(dn(in1_i[2*i+:2]), dp(in1_i[2*i+:2]))
                                   : enc(dp(in1_i[2*i+:2]), dn(in1_i[2*i+:2]));
    mp_init_d = ZM;
    for (int i = 0; i < Y; i++) mp_init_d[2*i+:2] = in2_i[2*i+:2];
    mc_sh_d = ZW;
    for (int i = D; i < W; i++) mc_sh_d[2*i+:2] = mc_q[2*(i-D)+:2];
    mp_sh_d = ZM;
    for (int i = 0; i < MP - D; i++) mp_sh_d[2*i+:2] = mp_q[2*(i+D)+:2];
    pp_d = ZW;
    pj   = ZW;
    for (int j = 0; j < D; j++) begin
      pj = ZW;
      for (int i = j; i < W; i++) pj[2*i+:2] = dmul(mc_q[2*(i-j)+:2], mp_q[2*j+:2]);
      pp_d = (j == 0) ? pj : sd_add(pp_d, pj);
    end
    acc_d = sd_add(acc_q, pp_q);
  end

`ifdef MSD_CONV_EN
  logic [W-1:0] acc_p, acc_n;
  logic [W:0]   bin_q, bin_d;
  always_comb begin
    acc_p = '0;
    acc_n = '0;
    for (int i = 0; i < W; i++) begin
      acc_p[i] = dp(acc_q[2*i+:2]);
      acc_n[i] = dn(acc_q[2*i+:2]);
    end
    bin_d = {1'b0, acc_p} - {1'b0, acc_n};
  end
  assign result_bin_o = bin_q;
`endif

  // The group sum formed in cycle k is folded into acc in cycle k+1, so CALC
  // runs N+1 cycles and keeps the two adder chains in separate stages.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= ZW;
      pp_q        <= ZW;
      mc_q        <= ZW;
      mp_q        <= ZM;
      out_valid_q <= 1'b0;
`ifdef MSD_CONV_EN
      bin_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_CALC: begin
          acc_q <= acc_d;
          pp_q  <= pp_d;
          mc_q  <= mc_sh_d;
          mp_q  <= mp_sh_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N)) begin
`ifdef MSD_CONV_EN
            state_q     <= S_CONV;
`else
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
`endif
          end
        end
`ifdef MSD_CONV_EN
        S_CONV: begin
          bin_q       <= bin_d;
          state_q     <= S_DONE;
          out_valid_q <= 1'b1;
        end
`endif
        S_DONE: begin
          if (out_ready_i) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
      if (accept) begin
        state_q     <= S_CALC;
        cnt_q       <= '0;
        acc_q       <= acc_en_i ? acc_q : ZW;
        pp_q        <= ZW;
        mc_q        <= mc_init_d;
        mp_q        <= mp_init_d;
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_msd_seq_mac.sv
// Bench for msd_seq_mac: a 4x4/D=2 unit for directed cases and a 33x33/D=4 unit for random ops,
// both checked against an integer multiply-accumulate model evaluated modulo 2^(X+Y+G).
module tb_msd_seq_mac;
  localparam int SW = 12;
  localparam int LW = 70;
`ifdef MSD_CONV_EN
  localparam int SLAT = 4;
  localparam int LLAT = 11;
`else
  localparam int SLAT = 3;
  localparam int LLAT = 10;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         s_rst, s_iv, s_ir, s_ae, s_ne, s_ov, s_or;
  logic [7:0]   s_a, s_b;
  logic [23:0]  s_res;
  logic         l_rst, l_iv, l_ir, l_ae, l_ne, l_ov, l_or;
  logic [65:0]  l_a, l_b;
  logic [139:0] l_res;
`ifdef MSD_CONV_EN
  logic [12:0]  s_bin;
  logic [70:0]  l_bin;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [127:0] s_acc, l_acc;

  msd_seq_mac #(.X(4), .Y(4), .D(2), .G(4)) u_s (
    .clk_i(clk), .rst_i(s_rst), .in_valid_i(s_iv), .in_ready_o(s_ir),
    .in1_i(s_a), .in2_i(s_b), .acc_en_i(s_ae), .neg_en_i(s_ne),
    .out_valid_o(s_ov), .out_ready_i(s_or), .result_o(s_res)
`ifdef MSD_CONV_EN
    , .result_bin_o(s_bin)
`endif
  );

  msd_seq_mac #(.X(33), .Y(33), .D(4), .G(4)) u_l (
    .clk_i(clk), .rst_i(l_rst), .in_valid_i(l_iv), .in_ready_o(l_ir),
    .in1_i(l_a), .in2_i(l_b), .acc_en_i(l_ae), .neg_en_i(l_ne),
    .out_valid_o(l_ov), .out_ready_i(l_or), .result_o(l_res)
`ifdef MSD_CONV_EN
    , .result_bin_o(l_bin)
`endif
  );

  // Signed value of an MSD digit string (01=-1, 11=+1, 10/00=0).
  function automatic logic signed [127:0] mval(input logic [139:0] v, input int nd);
    logic signed [127:0] r = 0;
    for (int i = 0; i < nd; i++) begin
      if (v[2*i+:2] == 2'b11) r = r + (128'sd1 <<< i);
      else if (v[2*i+:2] == 2'b01) r = r - (128'sd1 <<< i);
    end
    return r;
  endfunction

  function automatic logic has00(input logic [139:0] v, input int nd);
    for (int i = 0; i < nd; i++) if (v[2*i+:2] == 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [127:0] modw(input logic [127:0] v, input int w);
    return v & ((128'd1 << w) - 128'd1);
  endfunction

  function automatic logic [65:0] rdig();
    logic [65:0] r;
    for (int i = 0; i < 33; i++) r[2*i+:2] = 2'($urandom_range(3));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic s_accept(input logic [7:0] a, input logic [7:0] b, input logic ae, input logic ne);
    int k = 0;
    @(negedge clk);
    s_a = a; s_b = b; s_ae = ae; s_ne = ne; s_iv = 1'b1;
    while (!s_ir && k < 50) begin @(negedge clk); k++; end
    chk("s_accept_rdy", s_ir, 1);
    @(posedge clk); #1;
    s_iv = 1'b0; s_or = 1'b0;
  endtask

  task automatic s_release();
    s_or = 1'b1;
    @(posedge clk); #1;
    s_or = 1'b0;
  endtask

  task automatic s_op(input logic [7:0] a, input logic [7:0] b, input logic ae, input logic ne, input string tag);
    int lat = 0;
    s_accept(a, b, ae, ne);
    s_acc = modw((ae ? s_acc : 128'd0) + (ne ? -(mval(a, 4) * mval(b, 4)) : mval(a, 4) * mval(b, 4)), SW);
    while (!s_ov && lat < 50) begin @(posedge clk); #1; lat++; end
    chk({tag, "_lat"}, lat, SLAT);
    chk({tag, "_val"}, modw(mval(s_res, SW), SW), s_acc);
    chk({tag, "_no00"}, has00(s_res, SW), 0);
`ifdef MSD_CONV_EN
    chk({tag, "_bin"}, modw(128'(s_bin), SW), s_acc);
`endif
  endtask

  task automatic l_op(input logic [65:0] a, input logic [65:0] b, input logic ae, input logic ne, input string tag);
    int lat = 0;
    int k = 0;
    @(negedge clk);
    l_a = a; l_b = b; l_ae = ae; l_ne = ne; l_iv = 1'b1;
    while (!l_ir && k < 50) begin @(negedge clk); k++; end
    chk({tag, "_rdy"}, l_ir, 1);
    @(posedge clk); #1;
    l_iv = 1'b0; l_or = 1'b0;
    l_acc = modw((ae ? l_acc : 128'd0) + (ne ? -(mval(a, 33) * mval(b, 33)) : mval(a, 33) * mval(b, 33)), LW);
    while (!l_ov && lat < 50) begin @(posedge clk); #1; lat++; end
    chk({tag, "_lat"}, lat, LLAT);
    chk({tag, "_val"}, modw(mval(l_res, LW), LW), l_acc);
    chk({tag, "_no00"}, has00(l_res, LW), 0);
`ifdef MSD_CONV_EN
    chk({tag, "_bin"}, modw(128'(l_bin), LW), l_acc);
`endif
  endtask

  initial begin
    logic [23:0] r0;
    logic [65:0] ra, rb;
    s_rst = 1'b1; s_iv = 1'b0; s_a = '0; s_b = '0; s_ae = 1'b0; s_ne = 1'b0; s_or = 1'b0;
    l_rst = 1'b1; l_iv = 1'b0; l_a = '0; l_b = '0; l_ae = 1'b0; l_ne = 1'b0; l_or = 1'b0;
    s_acc = '0; l_acc = '0;
    repeat (3) @(posedge clk);
    #1; s_rst = 1'b0; l_rst = 1'b0;
    chk("rst_ov", s_ov, 0);
    chk("rst_ir", s_ir, 1);
    chk("rst_res", s_res, 24'hAAAAAA);
    chk("rst_l_res", l_res, {70{2'b10}});
`ifdef MSD_CONV_EN
    chk("rst_bin", s_bin, 0);
`endif

    // Worked examples: 5*-3, then accumulate -(7*2), then fresh 0*9.
    s_op(8'b10111011, 8'b10100101, 1'b0, 1'b0, "ex1");
    chk("ex1_m15", modw(mval(s_res, SW), SW), modw(-128'sd15, SW));
    s_release();
    s_op(8'b10111111, 8'b10101110, 1'b1, 1'b1, "ex2");
    chk("ex2_m29", modw(mval(s_res, SW), SW), modw(-128'sd29, SW));
    s_release();
    s_op(8'hAA, 8'b11101011, 1'b0, 1'b0, "ex3");
    chk("ex3_zero", modw(mval(s_res, SW), SW), 0);

    // Backpressure: result held, in_ready low, in_valid pulses ignored.
    r0 = s_res;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      s_a = 8'hFF; s_b = 8'hFF; s_ae = 1'b0; s_iv = (k % 2 == 0);
      chk("stall_ir", s_ir, 0);
      chk("stall_ov", s_ov, 1);
      chk("stall_res", s_res, r0);
    end
    @(negedge clk); s_iv = 1'b0;
    s_release();
    chk("stall_ov_drop", s_ov, 0);
    chk("stall_idle_rdy", s_ir, 1);
    s_op(8'b10111011, 8'b10100101, 1'b1, 1'b0, "post_stall");
    chk("post_stall_m15", modw(mval(s_res, SW), SW), modw(-128'sd15, SW));

    // Back-to-back: accept in DONE on the same edge as the output handshake.
    s_or = 1'b1;
    s_op(8'b10111111, 8'b11101011, 1'b1, 1'b0, "b2b");
    chk("b2b_48", modw(mval(s_res, SW), SW), 128'd48);
    s_release();

    // Reset in the second CALC cycle.
    s_accept(8'hFF, 8'hFF, 1'b1, 1'b0);
    @(posedge clk); #1;
    s_rst = 1'b1;
    @(posedge clk); #1;
    s_rst = 1'b0;
    s_acc = '0;
    chk("mrst_ov", s_ov, 0);
    chk("mrst_ir", s_ir, 1);
    chk("mrst_res", s_res, 24'hAAAAAA);
`ifdef MSD_CONV_EN
    chk("mrst_bin", s_bin, 0);
`endif
    s_op(8'b10111111, 8'b11101011, 1'b1, 1'b0, "post_rst");
    chk("post_rst_63", modw(mval(s_res, SW), SW), 128'd63);
    s_release();

    s_op(8'h00, 8'b11101011, 1'b0, 1'b0, "in1_00");
    chk("in1_00_zero", modw(mval(s_res, SW), SW), 0);
    s_release();

`ifdef MSD_CONV_EN
    s_op(8'b01010101, 8'hFF, 1'b0, 1'b0, "conv");
    chk("conv_m225", {{115{s_bin[12]}}, s_bin}, -128'sd225);
    s_release();
`endif

    for (int i = 0; i < 200; i++) begin
      ra = rdig(); rb = rdig();
      s_op(ra[7:0], rb[7:0], 1'($urandom_range(1)), 1'($urandom_range(1)), "s_rnd");
      if ($urandom_range(1) == 1) s_or = 1'b1;
      else s_release();
    end
    if (s_ov) s_release();

    for (int i = 0; i < 1000; i++) begin
      ra = rdig(); rb = rdig();
      l_op(ra, rb, 1'($urandom_range(1)), 1'($urandom_range(1)), "l_rnd");
      if ($urandom_range(1) == 1) l_or = 1'b1;
      else begin
        l_or = 1'b1;
        @(posedge clk); #1;
        l_or = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
